// File: rtl/pkg_reloj.sv
// Shared definitions for the time/date/timer edit sequencer: field codes,
// FSM state encoding and the field ring navigation helpers.
package pkg_reloj;

    localparam int CONT_W = 8;

    localparam logic [3:0] CAMPO_NINGUNO = 4'd0;
    localparam logic [3:0] CAMPO_HH_R    = 4'd1;
    localparam logic [3:0] CAMPO_MM_R    = 4'd2;
    localparam logic [3:0] CAMPO_SS_R    = 4'd3;
    localparam logic [3:0] CAMPO_DD_F    = 4'd4;
    localparam logic [3:0] CAMPO_MM_F    = 4'd5;
    localparam logic [3:0] CAMPO_AA_F    = 4'd6;
    localparam logic [3:0] CAMPO_SS_T    = 4'd8;
    localparam logic [3:0] CAMPO_MM_T    = 4'd9;
    localparam logic [3:0] CAMPO_HH_T    = 4'd10;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        EDITAR   = 2'd1,
        SOSTENER = 2'd2,
        REPETIR  = 2'd3
    } estado_t;

    function automatic logic [3:0] campo_siguiente(input logic [3:0] c);
        case (c)
            CAMPO_HH_R: return CAMPO_MM_R;
            CAMPO_MM_R: return CAMPO_SS_R;
            CAMPO_SS_R: return CAMPO_DD_F;
            CAMPO_DD_F: return CAMPO_MM_F;
            CAMPO_MM_F: return CAMPO_AA_F;
            CAMPO_AA_F: return CAMPO_SS_T;
            CAMPO_SS_T: return CAMPO_MM_T;
            CAMPO_MM_T: return CAMPO_HH_T;
            default:    return CAMPO_HH_R;
        endcase
    endfunction

    function automatic logic [3:0] campo_anterior(input logic [3:0] c);
        case (c)
            CAMPO_MM_R: return CAMPO_HH_R;
            CAMPO_SS_R: return CAMPO_MM_R;
            CAMPO_DD_F: return CAMPO_SS_R;
            CAMPO_MM_F: return CAMPO_DD_F;
            CAMPO_AA_F: return CAMPO_MM_F;
            CAMPO_SS_T: return CAMPO_AA_F;
            CAMPO_MM_T: return CAMPO_SS_T;
            CAMPO_HH_T: return CAMPO_MM_T;
            default:    return CAMPO_HH_T;
        endcase
    endfunction

    function automatic logic [CONT_W-1:0] cuenta_sat(input logic [CONT_W-1:0] c,
                                                     input logic en);
        if (en && (c != {CONT_W{1'b1}}))
            return c + 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector for debounced button levels. A level already high
// when reset is released is not armed until it has been seen low once.
module detector_flanco #(
    parameter int ANCHO = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ANCHO-1:0] entrada,
    output logic [ANCHO-1:0] flanco
);

    logic [ANCHO-1:0] previo_q, previo_d;
    logic [ANCHO-1:0] armado_q, armado_d;

    always_comb begin
        previo_d = entrada;
        armado_d = armado_q | ~entrada;
        flanco   = entrada & ~previo_q & armado_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            previo_q <= '0;
            armado_q <= '0;
        end else begin
            previo_q <= previo_d;
            armado_q <= armado_d;
        end
    end

endmodule

// File: rtl/control_edicion_hora.sv
// Edit-mode sequencer: button edges -> field select and Arriba/Abajo step pulses.
// Press-and-hold auto-repeat is built only with CONTROL_EDICION_AUTO_REPEAT_EN.
//
// state    | meaning
// REPOSO   | not editing, contadoresH = 0
// EDITAR   | editing, no step button held
// SOSTENER | step button held, waiting DELAY_TICKS before repeating
// REPETIR  | step button held, one pulse per tick_rep
module control_edicion_hora
    import pkg_reloj::*;
#(
    parameter int DELAY_TICKS   = 2,
    parameter int TIMEOUT_TICKS = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_rep,
    input  logic       btn_prog,
    input  logic       btn_derecha,
    input  logic       btn_izquierda,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    output logic [3:0] contadoresH,
    output logic       Arriba,
    output logic       Abajo,
    output logic       editando
);

    localparam int B_PROG = 0;
    localparam int B_DER  = 1;
    localparam int B_IZQ  = 2;
    localparam int B_ARR  = 3;
    localparam int B_ABA  = 4;

    localparam logic [CONT_W-1:0] LIM_INACT = CONT_W'(TIMEOUT_TICKS);

    logic [4:0] botones;
    logic [4:0] flanco;

    assign botones = {btn_abajo, btn_arriba, btn_izquierda, btn_derecha, btn_prog};

    detector_flanco #(.ANCHO(5)) u_flanco (
        .clk     (clk),
        .reset   (reset),
        .entrada (botones),
        .flanco  (flanco)
    );

    estado_t           estado_q, estado_d;
    logic [3:0]        campo_q, campo_d;
    logic              arriba_q, arriba_d;
    logic              abajo_q, abajo_d;
    logic              editando_q, editando_d;
    logic [CONT_W-1:0] inact_q, inact_d, inact_inc;
    logic              hay_flanco, campo_ok, paso_ok;

`ifdef CONTROL_EDICION_AUTO_REPEAT_EN
    localparam logic [CONT_W-1:0] LIM_RET = CONT_W'(DELAY_TICKS);

    logic              sube_q, sube_d;
    logic [CONT_W-1:0] retardo_q, retardo_d, retardo_inc;
    logic              sostenido, otro;

    assign sostenido = sube_q ? btn_arriba : btn_abajo;
    assign otro      = sube_q ? btn_abajo  : btn_arriba;
`endif

    always_comb begin
        estado_d   = estado_q;
        campo_d    = campo_q;
        arriba_d   = 1'b0;
        abajo_d    = 1'b0;
        inact_inc  = cuenta_sat(inact_q, tick_rep);
        inact_d    = inact_inc;
        hay_flanco = |flanco;
        campo_ok   = flanco[B_DER] ^ flanco[B_IZQ];
        paso_ok    = flanco[B_ARR] ^ flanco[B_ABA];
`ifdef CONTROL_EDICION_AUTO_REPEAT_EN
        sube_d      = sube_q;
        retardo_inc = cuenta_sat(retardo_q, tick_rep);
        retardo_d   = retardo_inc;
`endif

        if (estado_q == REPOSO) begin
            inact_d = '0;
            if (flanco[B_PROG]) begin
                estado_d = EDITAR;
                campo_d  = CAMPO_HH_R;
            end
        end else begin
            if (hay_flanco)
                inact_d = '0;
            if (flanco[B_PROG] || (!hay_flanco && inact_inc >= LIM_INACT)) begin
                estado_d = REPOSO;
                campo_d  = CAMPO_NINGUNO;
            end else if (campo_ok) begin
                campo_d  = flanco[B_DER] ? campo_siguiente(campo_q) : campo_anterior(campo_q);
                estado_d = EDITAR;
            end else begin
                case (estado_q)
                    EDITAR: begin
                        if (paso_ok) begin
                            arriba_d = flanco[B_ARR];
                            abajo_d  = flanco[B_ABA];
`ifdef CONTROL_EDICION_AUTO_REPEAT_EN
                            estado_d = SOSTENER;
                            sube_d   = flanco[B_ARR];
`endif
                        end
                    end
`ifdef CONTROL_EDICION_AUTO_REPEAT_EN
                    SOSTENER: begin
                        if (!sostenido || otro)
                            estado_d = EDITAR;
                        else if (tick_rep && retardo_inc >= LIM_RET)
                            estado_d = REPETIR;
                    end
                    REPETIR: begin
                        if (!sostenido || otro) begin
                            estado_d = EDITAR;
                        end else if (tick_rep) begin
                            arriba_d = sube_q;
                            abajo_d  = !sube_q;
                            inact_d  = '0;
                        end
                    end
`endif
                    default: estado_d = EDITAR;
                endcase
            end
        end

        // every state change restarts both timers
        if (estado_d != estado_q) begin
            inact_d = '0;
`ifdef CONTROL_EDICION_AUTO_REPEAT_EN
            retardo_d = '0;
`endif
        end
        editando_d = (estado_d != REPOSO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= REPOSO;
            campo_q    <= CAMPO_NINGUNO;
            arriba_q   <= 1'b0;
            abajo_q    <= 1'b0;
            editando_q <= 1'b0;
            inact_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            campo_q    <= campo_d;
            arriba_q   <= arriba_d;
            abajo_q    <= abajo_d;
            editando_q <= editando_d;
            inact_q    <= inact_d;
        end
    end

`ifdef CONTROL_EDICION_AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sube_q    <= 1'b0;
            retardo_q <= '0;
        end else begin
            sube_q    <= sube_d;
            retardo_q <= retardo_d;
        end
    end
`endif

    assign contadoresH = campo_q;
    assign Arriba      = arriba_q;
    assign Abajo       = abajo_q;
    assign editando    = editando_q;

endmodule
